// File: rtl/onchip_mem_copier.sv
// Avalon-MM block-copy engine: moves LEN words from SRC to DST inside a
// 256x32 single-port on-chip RAM, programmed through a 4-register slave.
module onchip_mem_copier #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ctl_address,
    input  logic              ctl_chipselect,
    input  logic              ctl_write,
    input  logic              ctl_read,
    input  logic [31:0]       ctl_writedata,
    output logic [31:0]       ctl_readdata,
    output logic              irq,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_LAT, S_WR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                ie_q, ie_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0]   dp_q, dp_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         ctl_readdata_q, ctl_readdata_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic                mem_chipselect_q, mem_chipselect_d;
    logic                mem_write_q, mem_write_d;
    logic [DATA_W-1:0]   mem_writedata_q, mem_writedata_d;

    logic                busy;
    logic                ctl_wr;
    logic                ctl_rd;
    logic                start;
    logic [LEN_W-1:0]    len_eff;
    logic                unused_wdata;

    assign busy    = (state_q != S_IDLE);
    assign ctl_wr  = ctl_chipselect & ctl_write;
    assign ctl_rd  = ctl_chipselect & ctl_read;
    assign start   = ctl_wr && (ctl_address == 2'd3) && ctl_writedata[0] && !busy;
    assign len_eff = (len_q > MAX_LEN) ? MAX_LEN : len_q;
    assign unused_wdata = ^ctl_writedata[31:LEN_W];

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so
        // no path through the branches below can leave a signal unassigned and
        // infer a latch.
        state_d          = state_q;
        src_d            = src_q;
        dst_d            = dst_q;
        len_d            = len_q;
        ie_d             = ie_q;
        done_d           = done_q;
        sp_d             = sp_q;
        dp_d             = dp_q;
        cnt_d            = cnt_q;
        ctl_readdata_d   = ctl_readdata_q;
        mem_address_d    = mem_address_q;
        mem_chipselect_d = mem_chipselect_q;
        mem_write_d      = mem_write_q;
        mem_writedata_d  = mem_writedata_q;

        if (ctl_wr && !busy) begin
            case (ctl_address)
                2'd0:    src_d = ctl_writedata[ADDR_W-1:0];
                2'd1:    dst_d = ctl_writedata[ADDR_W-1:0];
                2'd2:    len_d = ctl_writedata[LEN_W-1:0];
                default: ;
            endcase
        end

        // ie stays writable mid-copy; the W1C clear comes before any done-set
        // below so a completing copy on the same edge wins.
        if (ctl_wr && ctl_address == 2'd3) begin
            ie_d = ctl_writedata[1];
            if (ctl_writedata[2]) done_d = 1'b0;
        end

        if (ctl_rd) begin
            case (ctl_address)
                2'd0:    ctl_readdata_d = 32'(src_q);
                2'd1:    ctl_readdata_d = 32'(dst_q);
                2'd2:    ctl_readdata_d = 32'(len_q);
                default: ctl_readdata_d = {29'd0, done_q, ie_q, busy};
            endcase
        end

        // mem_* are registered: each branch sets the values seen in the next state.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d          = S_RD;
                        sp_d             = src_q;
                        dp_d             = dst_q;
                        cnt_d            = len_eff;
                        done_d           = 1'b0;
                        mem_address_d    = src_q;
                        mem_chipselect_d = 1'b1;
                        mem_write_d      = 1'b0;
                    end
                end
            end
            S_RD: begin
                state_d          = S_LAT;
                mem_chipselect_d = 1'b0;
            end
            S_LAT: begin
                state_d          = S_WR;
                mem_address_d    = dp_q;
                mem_chipselect_d = 1'b1;
                mem_write_d      = 1'b1;
                mem_writedata_d  = mem_readdata;
            end
            S_WR: begin
                sp_d        = sp_q + ADDR_W'(1);
                dp_d        = dp_q + ADDR_W'(1);
                cnt_d       = cnt_q - LEN_W'(1);
                mem_write_d = 1'b0;
                if (cnt_q == LEN_W'(1)) begin
                    state_d          = S_IDLE;
                    mem_chipselect_d = 1'b0;
                    done_d           = 1'b1;
                end else begin
                    state_d          = S_RD;
                    mem_address_d    = sp_q + ADDR_W'(1);
                    mem_chipselect_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q          <= S_IDLE;
            src_q            <= '0;
            dst_q            <= '0;
            len_q            <= '0;
            ie_q             <= 1'b0;
            done_q           <= 1'b0;
            sp_q             <= '0;
            dp_q             <= '0;
            cnt_q            <= '0;
            ctl_readdata_q   <= '0;
            mem_address_q    <= '0;
            mem_chipselect_q <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            src_q            <= src_d;
            dst_q            <= dst_d;
            len_q            <= len_d;
            ie_q             <= ie_d;
            done_q           <= done_d;
            sp_q             <= sp_d;
            dp_q             <= dp_d;
            cnt_q            <= cnt_d;
            ctl_readdata_q   <= ctl_readdata_d;
            mem_address_q    <= mem_address_d;
            mem_chipselect_q <= mem_chipselect_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
        end
    end

    assign ctl_readdata   = ctl_readdata_q;
    assign irq            = done_q & ie_q;
    assign mem_address    = mem_address_q;
    assign mem_byteenable = 4'hF;
    assign mem_chipselect = mem_chipselect_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_copier.sv
// Scoreboard bench for onchip_mem_copier: a 256x32 RAM model, directed copies,
// and a monitor that checks every RAM access and control read against queues.
module tb_onchip_mem_copier;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ctl_address = '0;
    logic        ctl_chipselect = 1'b0;
    logic        ctl_write = 1'b0;
    logic        ctl_read = 1'b0;
    logic [31:0] ctl_writedata = '0;
    logic [31:0] ctl_readdata;
    logic        irq;
    logic [7:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    onchip_mem_copier dut (
        .clk            (clk),
        .reset          (reset),
        .ctl_address    (ctl_address),
        .ctl_chipselect (ctl_chipselect),
        .ctl_write      (ctl_write),
        .ctl_read       (ctl_read),
        .ctl_writedata  (ctl_writedata),
        .ctl_readdata   (ctl_readdata),
        .irq            (irq),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: address registered, output unregistered; backdoor port for preload.
    logic [31:0] ram [256];
    logic [7:0]  ram_addr_q = '0;
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_clken && mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write) ram[mem_address] <= mem_writedata;
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    logic [7:0]  exp_rd[$];
    logic [39:0] exp_wr[$];
    logic [31:0] exp_rdata[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every RAM access and every control read response.
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= !reset && ctl_chipselect && ctl_read;

    always @(negedge clk) begin
        logic [39:0] e;
        if (rd_seen) begin
            if (exp_rdata.size() == 0) check("unexpected ctl read", ctl_readdata, 32'hDEAD_BEEF);
            else check("ctl_readdata", ctl_readdata, exp_rdata.pop_front());
        end
        if (mem_chipselect) begin
            if (mem_write) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check("unexpected mem write addr", {24'd0, mem_address}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_wr.pop_front();
                    check("mem wr addr", {24'd0, mem_address}, {24'd0, e[39:32]});
                    check("mem wr data", mem_writedata, e[31:0]);
                end
            end else begin
                if (exp_rd.size() == 0) check("unexpected mem read addr", {24'd0, mem_address}, 32'hFFFF_FFFF);
                else check("mem rd addr", {24'd0, mem_address}, {24'd0, exp_rd.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ctl_wr(input logic [1:0] a, input logic [31:0] d);
        ctl_chipselect = 1'b1; ctl_write = 1'b1; ctl_address = a; ctl_writedata = d;
        tick(1);
        ctl_chipselect = 1'b0; ctl_write = 1'b0;
    endtask

    task automatic ctl_rd(input logic [1:0] a, input logic [31:0] exp);
        exp_rdata.push_back(exp);
        ctl_chipselect = 1'b1; ctl_read = 1'b1; ctl_address = a;
        tick(1);
        ctl_chipselect = 1'b0; ctl_read = 1'b0;
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick(1);
        bd_we = 1'b0;
    endtask

    task automatic wait_irq(input int budget);
        int n = 0;
        while (!irq && n < budget) begin
            tick(1);
            n++;
        end
        check("irq raised before timeout", {31'd0, irq}, 32'd1);
    endtask

    task automatic expect_word(input logic [7:0] ra, input logic [7:0] wa, input logic [31:0] wd);
        exp_rd.push_back(ra);
        exp_wr.push_back({wa, wd});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int wr_base;

        // Background fill while reset is held: ram[i] = 5A5A_00ii.
        for (int i = 0; i < 256; i++) bd_write(8'(i), 32'h5A5A_0000 | 32'(i));

        // Reset state.
        check("reset irq", {31'd0, irq}, 32'd0);
        check("reset mem_chipselect", {31'd0, mem_chipselect}, 32'd0);
        check("reset mem_write", {31'd0, mem_write}, 32'd0);
        check("reset mem_address", {24'd0, mem_address}, 32'd0);
        check("mem_byteenable", {28'd0, mem_byteenable}, 32'hF);
        check("mem_clken", {31'd0, mem_clken}, 32'd1);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) ctl_rd(2'(a), 32'd0);
        check("idle irq", {31'd0, irq}, 32'd0);

        // Register widths.
        ctl_wr(2'd0, 32'hFFFF_FF10);
        ctl_rd(2'd0, 32'h10);
        ctl_wr(2'd2, 32'hFFFF_FFFF);
        ctl_rd(2'd2, 32'h1FF);

        // Basic copy 0x10..0x13 -> 0x80..0x83.
        for (int i = 0; i < 4; i++) bd_write(8'(8'h10 + i), 32'hCAFE_00A0 + 32'(i));
        ctl_wr(2'd0, 32'h10);
        ctl_wr(2'd1, 32'h80);
        ctl_wr(2'd2, 32'd4);
        expect_word(8'h10, 8'h80, 32'hCAFE_00A0);
        expect_word(8'h11, 8'h81, 32'hCAFE_00A1);
        expect_word(8'h12, 8'h82, 32'hCAFE_00A2);
        expect_word(8'h13, 8'h83, 32'hCAFE_00A3);
        ctl_wr(2'd3, 32'h3);
        t0 = cyc;
        ctl_rd(2'd3, 32'h3);
        wait_irq(100);
        check("copy1 busy cycles", 32'(cyc - t0), 32'd12);
        check("ram[80]", ram[8'h80], 32'hCAFE_00A0);
        check("ram[83]", ram[8'h83], 32'hCAFE_00A3);
        check("ram[84] untouched", ram[8'h84], 32'h5A5A_0084);
        ctl_rd(2'd3, 32'h6);
        ctl_wr(2'd3, 32'h4);
        check("irq after W1C", {31'd0, irq}, 32'd0);
        ctl_rd(2'd3, 32'h0);

        // Source wraps 0xFF -> 0x00.
        ctl_wr(2'd0, 32'hFE);
        ctl_wr(2'd1, 32'h40);
        ctl_wr(2'd2, 32'd4);
        expect_word(8'hFE, 8'h40, 32'h5A5A_00FE);
        expect_word(8'hFF, 8'h41, 32'h5A5A_00FF);
        expect_word(8'h00, 8'h42, 32'h5A5A_0000);
        expect_word(8'h01, 8'h43, 32'h5A5A_0001);
        ctl_wr(2'd3, 32'h3);
        t0 = cyc;
        wait_irq(100);
        check("wrap busy cycles", 32'(cyc - t0), 32'd12);
        ctl_wr(2'd3, 32'h4);
        check("irq cleared", {31'd0, irq}, 32'd0);

        // LEN=0: no RAM access, done one edge later.
        ctl_wr(2'd2, 32'd0);
        ctl_wr(2'd3, 32'h3);
        check("len0 irq next cycle", {31'd0, irq}, 32'd1);
        ctl_rd(2'd3, 32'h6);
        ctl_wr(2'd3, 32'h6);
        check("len0 W1C keeps ie", {31'd0, irq}, 32'd0);

        // Writes and restart during a LEN=8 copy are ignored.
        ctl_wr(2'd0, 32'h20);
        ctl_wr(2'd1, 32'hA0);
        ctl_wr(2'd2, 32'd8);
        for (int i = 0; i < 8; i++)
            expect_word(8'(8'h20 + i), 8'(8'hA0 + i), 32'h5A5A_0020 + 32'(i));
        wr_base = wr_cnt;
        ctl_wr(2'd3, 32'h3);
        t0 = cyc;
        tick(4);
        ctl_wr(2'd0, 32'h55);
        ctl_wr(2'd3, 32'h3);
        ctl_rd(2'd0, 32'h20);
        ctl_rd(2'd3, 32'h3);
        wait_irq(200);
        check("len8 busy cycles", 32'(cyc - t0), 32'd24);
        check("len8 write count", 32'(wr_cnt - wr_base), 32'd8);
        check("ram[a8] untouched", ram[8'hA8], 32'h5A5A_00A8);
        ctl_wr(2'd3, 32'h4);

        // Reset during cycle 7 of a LEN=4 copy: only two words land.
        ctl_wr(2'd0, 32'h30);
        ctl_wr(2'd1, 32'hC0);
        ctl_wr(2'd2, 32'd4);
        expect_word(8'h30, 8'hC0, 32'h5A5A_0030);
        expect_word(8'h31, 8'hC1, 32'h5A5A_0031);
        exp_rd.push_back(8'h32);
        ctl_wr(2'd3, 32'h3);
        tick(6);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("abort mem_write", {31'd0, mem_write}, 32'd0);
        check("abort mem_chipselect", {31'd0, mem_chipselect}, 32'd0);
        check("abort irq", {31'd0, irq}, 32'd0);
        ctl_rd(2'd3, 32'h0);
        ctl_rd(2'd0, 32'h0);
        check("ram[c0]", ram[8'hC0], 32'h5A5A_0030);
        check("ram[c1]", ram[8'hC1], 32'h5A5A_0031);
        check("ram[c2] untouched", ram[8'hC2], 32'h5A5A_00C2);
        check("ram[c3] untouched", ram[8'hC3], 32'h5A5A_00C3);

        tick(3);
        check("mem read queue drained", 32'(exp_rd.size()), 32'd0);
        check("mem write queue drained", 32'(exp_wr.size()), 32'd0);
        check("ctl read queue drained", 32'(exp_rdata.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
